// File: rtl/fwrisc_wb_pkg.sv
// Shared types for the fwrisc write-back arbiter: register address/data widths
// and the buffered write entry.
package fwrisc_wb_pkg;
   localparam int REG_ADDR_W = 6;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] waddr;
      logic [XLEN-1:0]       wdata;
   } wb_entry_t;
endpackage

// File: rtl/fwrisc_wb_fifo.sv
// Synchronous FIFO of write-back entries. Entries are presented oldest-first
// with per-slot valid bits so the parent can compare against every queued write.
module fwrisc_wb_fifo
   import fwrisc_wb_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  wb_entry_t             push_entry,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output wb_entry_t [DEPTH-1:0] entries,
   output logic [DEPTH-1:0]      valid
);
   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries[i] = mem[rd_ptr + PTR_W'(i)];
         valid[i]   = (CNT_W'(i) < count);
      end
   end
endmodule

// File: rtl/fwrisc_wb_arbiter.sv
// Write-back arbiter merging execute results and load responses onto the
// register file write port, with RAW hazard reporting. Optional forwarding
// build: define FWRISC_WB_BYPASS_EN.
module fwrisc_wb_arbiter
   import fwrisc_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] ex_waddr,
   input  logic [XLEN-1:0]       ex_wdata,
   input  logic                  ld_issue,
   output logic                  ld_issue_rdy,
   input  logic [REG_ADDR_W-1:0] ld_waddr,
   input  logic                  ld_rsp_valid,
   input  logic [XLEN-1:0]       ld_rsp_data,
   input  logic [REG_ADDR_W-1:0] ra_raddr,
   input  logic [REG_ADDR_W-1:0] rb_raddr,
   output logic                  ra_hazard,
   output logic                  rb_hazard,
   output logic [REG_ADDR_W-1:0] rd_waddr,
   output logic [XLEN-1:0]       rd_wdata,
   output logic                  rd_wen
`ifdef FWRISC_WB_BYPASS_EN
   ,
   output logic                  ra_byp_valid,
   output logic                  rb_byp_valid,
   output logic [XLEN-1:0]       ra_byp_data,
   output logic [XLEN-1:0]       rb_byp_data
`endif
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                       ld_pend;
   logic [REG_ADDR_W-1:0]      ld_addr;
   logic                       rsp_fire;
   logic                       ld_write;
   logic                       issue_fire;
   logic                       ex_nz;
   logic                       ex_fire;
   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CNT_W-1:0]           fifo_count;
   wb_entry_t [FIFO_DEPTH-1:0] fifo_entries;
   logic [FIFO_DEPTH-1:0]      fifo_valid;
   wb_entry_t                  ex_entry;
   wb_entry_t                  wb_next;
   logic                       wen_next;
   logic                       ra_pend_hit;
   logic                       rb_pend_hit;
   logic                       ra_out_hit;
   logic                       rb_out_hit;

   // A response with nothing outstanding (e.g. straight after reset) is ignored.
   assign rsp_fire     = ld_rsp_valid && ld_pend;
   assign ld_write     = rsp_fire && (ld_addr != '0);
   assign ld_issue_rdy = !ld_pend || ld_rsp_valid;
   assign issue_fire   = ld_issue && ld_issue_rdy;

   assign ex_nz     = (ex_waddr != '0);
   assign ex_ready  = !fifo_full && !(ld_pend && ex_nz && (ex_waddr == ld_addr));
   assign ex_fire   = ex_valid && ex_ready;
   assign ex_entry  = '{waddr: ex_waddr, wdata: ex_wdata};
   // The execute write skips the FIFO only when nothing older competes for the port.
   assign fifo_pop  = !fifo_empty && !ld_write;
   assign fifo_push = ex_fire && ex_nz && (!fifo_empty || ld_write);

   fwrisc_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry (ex_entry),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .entries    (fifo_entries),
      .valid      (fifo_valid)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         ld_pend <= 1'b0;
      end else if (issue_fire) begin
         ld_pend <= 1'b1;
      end else if (rsp_fire) begin
         ld_pend <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (issue_fire) ld_addr <= ld_waddr;
   end

   always_comb begin
      wen_next = 1'b0;
      wb_next  = '0;
      if (ld_write) begin
         wen_next = 1'b1;
         wb_next  = '{waddr: ld_addr, wdata: ld_rsp_data};
      end else if (!fifo_empty) begin
         wen_next = 1'b1;
         wb_next  = fifo_entries[0];
      end else if (ex_fire && ex_nz) begin
         wen_next = 1'b1;
         wb_next  = ex_entry;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_wen   <= 1'b0;
         rd_waddr <= '0;
         rd_wdata <= '0;
      end else begin
         rd_wen <= wen_next;
         if (wen_next) begin
            rd_waddr <= wb_next.waddr;
            rd_wdata <= wb_next.wdata;
         end
      end
   end

   assign ra_pend_hit = ld_pend && (ld_addr == ra_raddr);
   assign rb_pend_hit = ld_pend && (ld_addr == rb_raddr);
   assign ra_out_hit  = rd_wen && (rd_waddr == ra_raddr);
   assign rb_out_hit  = rd_wen && (rd_waddr == rb_raddr);

`ifdef FWRISC_WB_BYPASS_EN
   assign ra_hazard = (ra_raddr != '0) && ra_pend_hit;
   assign rb_hazard = (rb_raddr != '0) && rb_pend_hit;

   // Later matches override earlier ones, so the youngest queued write wins.
   always_comb begin
      ra_byp_valid = 1'b0;
      ra_byp_data  = '0;
      rb_byp_valid = 1'b0;
      rb_byp_data  = '0;
      if (ra_raddr != '0 && ra_out_hit) begin
         ra_byp_valid = 1'b1;
         ra_byp_data  = rd_wdata;
      end
      if (rb_raddr != '0 && rb_out_hit) begin
         rb_byp_valid = 1'b1;
         rb_byp_data  = rd_wdata;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ra_raddr != '0 && fifo_valid[i] && fifo_entries[i].waddr == ra_raddr) begin
            ra_byp_valid = 1'b1;
            ra_byp_data  = fifo_entries[i].wdata;
         end
         if (rb_raddr != '0 && fifo_valid[i] && fifo_entries[i].waddr == rb_raddr) begin
            rb_byp_valid = 1'b1;
            rb_byp_data  = fifo_entries[i].wdata;
         end
      end
   end
`else
   logic ra_fifo_hit;
   logic rb_fifo_hit;

   always_comb begin
      ra_fifo_hit = 1'b0;
      rb_fifo_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_valid[i] && fifo_entries[i].waddr == ra_raddr) ra_fifo_hit = 1'b1;
         if (fifo_valid[i] && fifo_entries[i].waddr == rb_raddr) rb_fifo_hit = 1'b1;
      end
   end

   assign ra_hazard = (ra_raddr != '0) && (ra_pend_hit || ra_fifo_hit || ra_out_hit);
   assign rb_hazard = (rb_raddr != '0) && (rb_pend_hit || rb_fifo_hit || rb_out_hit);
`endif

   ap_issue_protocol: assert property (@(posedge clock) disable iff (reset)
      !(ld_issue && !ld_issue_rdy));
   ap_fifo_bound: assert property (@(posedge clock) disable iff (reset)
      fifo_count <= CNT_W'(FIFO_DEPTH));
endmodule
